// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wr_arbiter
// Brief   : Round-robin arbiter sharing one fifo write port among NumReq
//           valid/ready producers, with grants of up to MaxBurst beats.
// Rev     : 1.0
// ============================================================================
module fifo_wr_arbiter #(
  parameter int DataWidth = 32,
  parameter int NumReq    = 4,
  parameter int MaxBurst  = 4,
  parameter int IdWidth   = $clog2(NumReq)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NumReq-1:0]           reqValid,
  input  logic [NumReq*DataWidth-1:0] reqData,
  output logic [NumReq-1:0]           reqReady,
  input  logic                        full,
  output logic                        writeEn,
  output logic [DataWidth-1:0]        writeData,
  output logic [IdWidth-1:0]          grantId,
  output logic                        busy
);

  localparam int                     c_cnt_width = $clog2(MaxBurst + 1);
  localparam logic [IdWidth-1:0]     c_last_id   = IdWidth'(NumReq - 1);
  localparam logic [c_cnt_width-1:0] c_max_beats = c_cnt_width'(MaxBurst);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                 r_state;
  logic [IdWidth-1:0]     r_owner;
  logic [IdWidth-1:0]     r_rr_ptr;
  logic [c_cnt_width-1:0] r_beat_cnt;

  logic [DataWidth-1:0]   w_data [NumReq];
  logic                   w_found;
  logic [IdWidth-1:0]     w_winner;
  logic [IdWidth-1:0]     w_sel;
  logic [c_cnt_width-1:0] w_cnt_inc;

  genvar gi;
  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_unpack
      assign w_data[gi] = reqData[gi*DataWidth +: DataWidth];
    end
  endgenerate

  function automatic logic [IdWidth-1:0] f_next(input logic [IdWidth-1:0] id);
    return (id == c_last_id) ? '0 : id + IdWidth'(1);
  endfunction

  // First valid requester at or above rrPtr, wrapping; defaults to rrPtr.
  always_comb begin
    int                 idx;
    logic [IdWidth-1:0] cand;
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    idx      = 0;
    cand     = '0;
    for (int k = 0; k < NumReq; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      cand = IdWidth'(idx);
      if (!w_found && reqValid[cand]) begin
        w_found  = 1'b1;
        w_winner = cand;
      end
    end
  end

  assign w_sel     = (r_state == S_BURST) ? r_owner : w_winner;
  assign w_cnt_inc = r_beat_cnt + c_cnt_width'(1);

  // Ready is combinational so a change in full takes effect the same cycle.
  always_comb begin
    reqReady = '0;
    if (!rst && !full) begin
      if (r_state == S_BURST) reqReady[r_owner] = 1'b1;
      else if (w_found)       reqReady[w_winner] = 1'b1;
    end
  end

  assign writeEn   = |(reqValid & reqReady);
  assign writeData = w_data[w_sel];
  assign grantId   = w_sel;
  assign busy      = (r_state == S_BURST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found && !full) begin
            if (MaxBurst == 1) begin
              r_rr_ptr <= f_next(w_winner);
            end else begin
              r_state    <= S_BURST;
              r_owner    <= w_winner;
              r_beat_cnt <= c_cnt_width'(1);
            end
          end
        end
        S_BURST: begin
          // Release on owner dropping valid, or on the beat that fills the burst.
          if (!reqValid[r_owner] || (!full && w_cnt_inc == c_max_beats)) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= f_next(r_owner);
            r_beat_cnt <= '0;
          end else if (!full) begin
            r_beat_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// Testbench for fifo_wr_arbiter: directed and random producer traffic,
// expected beats and status predicted by a grant-level model into queues.
module tb_fifo_wr_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int IW = 2;

  logic             clk;
  logic             rst;
  logic             full;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             write_en;
  logic [DW-1:0]    write_data;
  logic [IW-1:0]    grant_id;
  logic             busy;

  logic             rst1;
  logic             full1;
  logic [NR-1:0]    req_valid1;
  logic [NR*DW-1:0] req_data1;
  logic [NR-1:0]    req_ready1;
  logic             write_en1;
  logic [DW-1:0]    write_data1;
  logic [IW-1:0]    grant_id1;
  logic             busy1;

  fifo_wr_arbiter #(.DataWidth(DW), .NumReq(NR), .MaxBurst(MB)) dut (
    .clk(clk), .rst(rst), .reqValid(req_valid), .reqData(req_data),
    .reqReady(req_ready), .full(full), .writeEn(write_en),
    .writeData(write_data), .grantId(grant_id), .busy(busy)
  );

  fifo_wr_arbiter #(.DataWidth(DW), .NumReq(NR), .MaxBurst(1)) dut1 (
    .clk(clk), .rst(rst1), .reqValid(req_valid1), .reqData(req_data1),
    .reqReady(req_ready1), .full(full1), .writeEn(write_en1),
    .writeData(write_data1), .grantId(grant_id1), .busy(busy1)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    bit            chk;
    bit            we;
    int            gid;
    bit            bsy;
    logic [NR-1:0] rdy;
  } stat_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } beat_t;

  stat_t stat_q[$];
  beat_t beat_q[$];

  int checks = 0;
  int errors = 0;

  // Grant-level model: who holds the port, beats used, and the next start point.
  int            m_owner;
  int            m_ptr;
  int            m_beats;
  bit            pv [NR];
  logic [DW-1:0] pd [NR];
  int            acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic release_grant();
    m_ptr   = (m_owner + 1) % NR;
    m_owner = -1;
    m_beats = 0;
  endtask

  task automatic step(input bit r, input bit f, input bit chk);
    stat_t s;
    beat_t b;
    int    w;
    int    idx;
    rst  = r;
    full = f;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = pv[i];
      req_data[i*DW +: DW]   = pd[i];
    end
    s.bsy = (m_owner >= 0);
    w = -1;
    for (int k = 0; k < NR; k++) begin
      idx = (m_ptr + k) % NR;
      if (w < 0 && pv[idx]) w = idx;
    end
    s.gid = s.bsy ? m_owner : ((w >= 0) ? w : m_ptr);
    s.rdy = '0;
    if (!r && !f) begin
      if (s.bsy)       s.rdy[m_owner] = 1'b1;
      else if (w >= 0) s.rdy[w] = 1'b1;
    end
    acc = -1;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_beats = 0;
    end else if (s.bsy) begin
      if (!pv[m_owner]) begin
        release_grant();
      end else if (!f) begin
        acc = m_owner;
        m_beats++;
        if (m_beats == MB) release_grant();
      end
    end else if (w >= 0 && !f) begin
      acc     = w;
      m_owner = w;
      m_beats = 1;
      if (m_beats == MB) release_grant();
    end
    s.we  = (acc >= 0);
    s.chk = chk;
    stat_q.push_back(s);
    if (acc >= 0) begin
      b.id   = acc;
      b.data = pd[acc];
      beat_q.push_back(b);
    end
    @(posedge clk);
    #1;
    if (acc >= 0) pd[acc] = pd[acc] + 1;
  endtask

  // Monitor: status every cycle, beats whenever the DUT writes.
  always @(negedge clk) begin
    stat_t s;
    beat_t b;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      if (s.chk) begin
        check("busy", 64'(busy), 64'(s.bsy));
        check("grantId", 64'(grant_id), 64'(s.gid));
        check("reqReady", 64'(req_ready), 64'(s.rdy));
        check("writeEn", 64'(write_en), 64'(s.we));
      end
    end
    if (write_en === 1'b1) begin
      if (full === 1'b1) check("write_while_full", 64'(1), 64'(0));
      if (beat_q.size() == 0) begin
        check("unexpected_beat", 64'(write_data), 64'hDEAD);
      end else begin
        b = beat_q.pop_front();
        check("beat_data", 64'(write_data), 64'(b.data));
        check("beat_id", 64'(grant_id), 64'(b.id));
      end
    end
  end

  task automatic clear_prod();
    for (int i = 0; i < NR; i++) pv[i] = 1'b0;
  endtask

  initial begin
    int beats;
    int guard;
    m_owner = -1;
    m_ptr   = 0;
    m_beats = 0;
    acc     = -1;
    for (int i = 0; i < NR; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    rst1       = 1'b1;
    full1      = 1'b0;
    req_valid1 = '1;
    for (int i = 0; i < NR; i++) req_data1[i*DW +: DW] = DW'(32'h100 + i);

    step(1'b1, 1'b0, 1'b0);

    // Single producer 2, six beats 0x20..0x25 across a 4-beat and a 2-beat grant.
    pv[2] = 1'b1;
    pd[2] = 32'h20;
    beats = 0;
    guard = 0;
    while (beats < 6 && guard < 20) begin
      step(1'b0, 1'b0, 1'b1);
      if (acc == 2) beats++;
      guard++;
    end
    check("long_burst_beats", 64'(beats), 64'(6));
    pv[2] = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    check("rrptr_after_burst", 64'(grant_id), 64'(3));
    step(1'b0, 1'b0, 1'b1);

    // Full for three cycles after the second beat of producer 1.
    step(1'b1, 1'b0, 1'b1);
    pv[1] = 1'b1;
    pd[1] = 32'h10;
    repeat (2) step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b1);
    pv[1] = 1'b0;
    repeat (2) step(1'b0, 1'b0, 1'b1);

    // Owner 0 drops valid after two beats while producer 3 waits.
    step(1'b1, 1'b0, 1'b1);
    pv[0] = 1'b1; pd[0] = 32'hA0;
    pv[3] = 1'b1; pd[3] = 32'hD0;
    repeat (2) step(1'b0, 1'b0, 1'b1);
    pv[0] = 1'b0;
    repeat (2) step(1'b0, 1'b0, 1'b1);
    pv[3] = 1'b0;
    repeat (2) step(1'b0, 1'b0, 1'b1);

    // Reset during beat 2 of producer 2; producer 0 must win afterwards.
    step(1'b1, 1'b0, 1'b1);
    pv[2] = 1'b1; pd[2] = 32'h50;
    step(1'b0, 1'b0, 1'b1);
    pv[0] = 1'b1; pd[0] = 32'h60;
    step(1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, 1'b1);
    clear_prod();
    repeat (2) step(1'b0, 1'b0, 1'b1);

    // Full from reset for ten cycles with everyone valid.
    for (int i = 0; i < NR; i++) begin
      pv[i] = 1'b1;
      pd[i] = DW'(32'hF00 + 32'h10 * i);
    end
    step(1'b1, 1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b0, 1'b1);
    clear_prod();
    repeat (2) step(1'b0, 1'b0, 1'b1);

    // Random traffic obeying the producer contract.
    repeat (1500) begin
      for (int i = 0; i < NR; i++) begin
        if (!pv[i] || acc == i) begin
          pv[i] = ($urandom % 4) != 0;
          pd[i] = $urandom;
        end
      end
      step(($urandom % 150) == 0, ($urandom % 5) == 0, 1'b1);
    end
    step(1'b1, 1'b0, 1'b1);
    check("beat_queue_drained", 64'(beat_q.size()), 64'(0));
    check("stat_queue_drained", 64'(stat_q.size()), 64'(0));

    // MaxBurst=1 instance: single-beat grants rotate 0,1,2,3,0,1.
    rst1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("mb1_grant", 64'(grant_id1), 64'(k % NR));
      check("mb1_we", 64'(write_en1), 64'(1));
      check("mb1_data", 64'(write_data1), 64'(32'h100 + (k % NR)));
      check("mb1_busy", 64'(busy1), 64'(0));
    end
    @(posedge clk);
    #1;
    full1 = 1'b1;
    @(negedge clk);
    check("mb1_full_we", 64'(write_en1), 64'(0));
    check("mb1_full_ready", 64'(req_ready1), 64'(0));
    check("mb1_full_grant", 64'(grant_id1), 64'(2));
    @(posedge clk);
    #1;
    full1 = 1'b0;
    @(negedge clk);
    check("mb1_resume_grant", 64'(grant_id1), 64'(2));
    check("mb1_resume_we", 64'(write_en1), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
